// File: rtl/xor_rx_pkg.sv
// Shared sizes, FSM state encoding and error codes for the XOR decrypt receiver.
package xor_rx_pkg;

    localparam int MSG_SIZE_DEF = 64;
    localparam int KEY_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        DONE     = 2'd2,
        WAIT_LOW = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;
    localparam logic [1:0] ERR_NOKEY = 2'b11;

endpackage

// File: rtl/rx_key_loader.sv
// Serial key loader: MSB-first shift register with a saturating bit count and
// a ready flag that is only granted when a complete key has been shifted in.
module rx_key_loader
    import xor_rx_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                key_in,
    input  logic                key_flag,
    output logic [KEY_SIZE-1:0] key,
    output logic                key_ready
);

    localparam int CW = $clog2(KEY_SIZE) + 1;
    localparam logic [CW-1:0] KEY_FULL = CW'(KEY_SIZE);

    logic [CW-1:0] key_cnt;
    logic          flag_q;

    // A flag rise restarts the load and already captures its first bit, so the
    // previous key is never reported ready while it is being overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key       <= '0;
            key_cnt   <= '0;
            key_ready <= 1'b0;
            flag_q    <= 1'b0;
        end else if (ena) begin
            flag_q <= key_flag;
            if (key_flag && !flag_q) begin
                key       <= {key[KEY_SIZE-2:0], key_in};
                key_cnt   <= CW'(1);
                key_ready <= 1'b0;
            end else if (key_flag && (key_cnt < KEY_FULL)) begin
                key     <= {key[KEY_SIZE-2:0], key_in};
                key_cnt <= key_cnt + CW'(1);
            end else if (!key_flag && flag_q && (key_cnt == KEY_FULL)) begin
                key_ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_decrypt_rx.sv
// Receive side of the serial XOR cipher: deserializes a ciphertext frame and
// XORs it with the repeating serially-loaded key into a parallel plaintext word.
module xor_decrypt_rx
    import xor_rx_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int KEY_SIZE = KEY_SIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     iKey_in,
    input  logic                     iKey_flag,
    input  logic                     iData_in,
    input  logic                     iData_flag,
    output logic [MSG_SIZE-1:0]      oPlaintext,
    output logic                     oValid,
    output logic                     oBusy,
    output logic                     oKey_ready,
    output logic [$clog2(MSG_SIZE):0] oBit_counter,
    output logic                     oError,
    output logic [1:0]               oError_code
);

    localparam int CNT_W = $clog2(MSG_SIZE) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MSG_SIZE);

    rx_state_t             state, state_next;
    logic [MSG_SIZE-1:0]   shreg;
    logic [KEY_SIZE-1:0]   key;
    logic [MSG_SIZE-1:0]   key_rep;
    logic [CNT_W-1:0]      cnt_next;
    logic                  shift_en;
    logic                  load_pt;
    logic                  valid_next;
    logic                  err_next;
    logic [1:0]            code_next;
    logic                  long_seen, long_seen_next;

    rx_key_loader #(.KEY_SIZE(KEY_SIZE)) u_key_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .key_in    (iKey_in),
        .key_flag  (iKey_flag),
        .key       (key),
        .key_ready (oKey_ready)
    );

    assign key_rep = {(MSG_SIZE / KEY_SIZE){key}};
    assign oBusy   = (state == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // The long-frame error may be raised already in DONE when bit MSG_SIZE+1
    // arrives there; long_seen keeps WAIT_LOW from reporting it a second time.
    always_comb begin
        state_next     = state;
        cnt_next       = oBit_counter;
        shift_en       = 1'b0;
        load_pt        = 1'b0;
        valid_next     = 1'b0;
        err_next       = 1'b0;
        code_next      = oError_code;
        long_seen_next = long_seen;
        case (state)
            IDLE: begin
                long_seen_next = 1'b0;
                if (iData_flag) begin
                    shift_en   = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = RECV;
                end
            end
            RECV: begin
                if (iData_flag) begin
                    shift_en = 1'b1;
                    cnt_next = oBit_counter + CNT_W'(1);
                    if ((oBit_counter + CNT_W'(1)) == CNT_FULL) begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                    code_next  = ERR_SHORT;
                end
            end
            DONE: begin
                state_next = WAIT_LOW;
                if (oKey_ready) begin
                    load_pt    = 1'b1;
                    valid_next = 1'b1;
                    if (iData_flag) begin
                        err_next       = 1'b1;
                        code_next      = ERR_LONG;
                        long_seen_next = 1'b1;
                    end
                end else begin
                    err_next  = 1'b1;
                    code_next = ERR_NOKEY;
                end
            end
            WAIT_LOW: begin
                if (iData_flag) begin
                    if (!long_seen) begin
                        err_next       = 1'b1;
                        code_next      = ERR_LONG;
                        long_seen_next = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulses always clear after one cycle, even while ena freezes everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg        <= '0;
            oPlaintext   <= '0;
            oBit_counter <= '0;
            oValid       <= 1'b0;
            oError       <= 1'b0;
            oError_code  <= 2'b00;
            long_seen    <= 1'b0;
        end else begin
            oValid <= 1'b0;
            oError <= 1'b0;
            if (ena) begin
                oBit_counter <= cnt_next;
                oValid       <= valid_next;
                oError       <= err_next;
                oError_code  <= code_next;
                long_seen    <= long_seen_next;
                if (shift_en) begin
                    shreg <= {shreg[MSG_SIZE-2:0], iData_in};
                end
                if (load_pt) begin
                    oPlaintext <= shreg ^ key_rep;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_decrypt_rx.sv
// Directed bench for xor_decrypt_rx: stimulus pushes expected pulses into a
// queue that an independent monitor pops whenever oValid or oError fires.
module tb_xor_decrypt_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        iKey_in = 1'b0;
    logic        iKey_flag = 1'b0;
    logic        iData_in = 1'b0;
    logic        iData_flag = 1'b0;
    logic [63:0] oPlaintext;
    logic        oValid;
    logic        oBusy;
    logic        oKey_ready;
    logic [6:0]  oBit_counter;
    logic        oError;
    logic [1:0]  oError_code;

    typedef struct {
        bit          isValid;
        logic [63:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    xor_decrypt_rx #(.MSG_SIZE(64), .KEY_SIZE(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .iKey_in      (iKey_in),
        .iKey_flag    (iKey_flag),
        .iData_in     (iData_in),
        .iData_flag   (iData_flag),
        .oPlaintext   (oPlaintext),
        .oValid       (oValid),
        .oBusy        (oBusy),
        .oKey_ready   (oKey_ready),
        .oBit_counter (oBit_counter),
        .oError       (oError),
        .oError_code  (oError_code)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] encrypt(input logic [63:0] p, input logic [7:0] k);
        return p ^ {8{k}};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
        end
    endtask

    task automatic pushValid(input logic [63:0] p);
        exp_t e;
        e.isValid = 1'b1;
        e.data    = p;
        e.code    = 2'b00;
        expQ.push_back(e);
    endtask

    task automatic pushError(input logic [1:0] c);
        exp_t e;
        e.isValid = 1'b0;
        e.data    = 64'h0;
        e.code    = c;
        expQ.push_back(e);
    endtask

    task automatic popAndCheck(input bit isValid, input logic [63:0] data, input logic [1:0] code);
        exp_t e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_pulse: got valid=%0b data=%h code=%b, wanted no pulse",
                     isValid, data, code);
        end else begin
            e = expQ.pop_front();
            if (e.isValid != isValid || (isValid && e.data !== data) || (!isValid && e.code !== code)) begin
                bad++;
                $display("[TB] FAIL scoreboard: got valid=%0b data=%h code=%b, wanted valid=%0b data=%h code=%b",
                         isValid, data, code, e.isValid, e.data, e.code);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (oValid === 1'b1) popAndCheck(1'b1, oPlaintext, 2'b00);
            if (oError === 1'b1) popAndCheck(1'b0, 64'h0, oError_code);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, wanted finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendKey(input logic [15:0] pat, input int nbits);
        logic [15:0] sh;
        sh = pat;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            iKey_flag = 1'b1;
            iKey_in   = sh[15];
            sh        = {sh[14:0], 1'b0};
        end
        @(negedge clk);
        iKey_flag = 1'b0;
        iKey_in   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] cipher, input int nbits, input int pauseAt, input int resetAt);
        logic [63:0] sh;
        sh = cipher;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == resetAt) begin
                rst_n      = 1'b0;
                iData_flag = 1'b0;
                #1;
                checkOutput("rst_plaintext", oPlaintext, 64'h0);
                checkOutput("rst_key_ready", oKey_ready, 64'h0);
                checkOutput("rst_bit_counter", oBit_counter, 64'h0);
                checkOutput("rst_busy", oBusy, 64'h0);
                checkOutput("rst_error_code", oError_code, 64'h0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (i == pauseAt) begin
                for (int p = 0; p < 5; p++) begin
                    ena        = 1'b0;
                    iData_flag = p[0];
                    iData_in   = ~iData_in;
                    @(negedge clk);
                end
                checkOutput("ena_freeze_count", oBit_counter, pauseAt);
                checkOutput("ena_freeze_busy", oBusy, 64'h1);
                ena = 1'b1;
            end
            iData_flag = 1'b1;
            iData_in   = sh[63];
            sh         = {sh[62:0], 1'b1};
        end
        @(negedge clk);
        iData_flag = 1'b0;
        iData_in   = 1'b0;
    endtask

    initial begin
        idle(3);
        checkOutput("reset_plaintext", oPlaintext, 64'h0);
        checkOutput("reset_valid", oValid, 64'h0);
        checkOutput("reset_busy", oBusy, 64'h0);
        checkOutput("reset_key_ready", oKey_ready, 64'h0);
        checkOutput("reset_bit_counter", oBit_counter, 64'h0);
        checkOutput("reset_error", oError, 64'h0);
        checkOutput("reset_error_code", oError_code, 64'h0);
        rst_n = 1'b1;
        ena   = 1'b1;
        idle(2);

        // frame with no key loaded
        pushError(2'b11);
        applyStimulus(64'h5555_AAAA_0F0F_F0F0, 64, -1, -1);
        idle(3);
        checkOutput("nokey_plaintext_held", oPlaintext, 64'h0);

        // nominal frame, including oValid timing
        sendKey({8'hAC, 8'h00}, 8);
        idle(2);
        checkOutput("key_ready_after_load", oKey_ready, 64'h1);
        pushValid(64'h0123_4567_89AB_CDEF);
        applyStimulus(64'hAD8F_E9CB_2507_6143, 64, -1, -1);
        checkOutput("nominal_count", oBit_counter, 64'd64);
        checkOutput("nominal_valid_not_early", oValid, 64'h0);
        @(negedge clk);
        checkOutput("nominal_valid_timing", oValid, 64'h1);
        idle(3);

        // short frame, then a full one
        pushError(2'b01);
        applyStimulus(encrypt(64'h1111_2222_3333_4444, 8'hAC), 40, -1, -1);
        idle(3);
        checkOutput("short_plaintext_held", oPlaintext, 64'h0123_4567_89AB_CDEF);
        checkOutput("short_code_held", oError_code, 64'h1);
        checkOutput("short_count_cleared", oBit_counter, 64'h0);
        pushValid(64'hFEDC_BA98_7654_3210);
        applyStimulus(encrypt(64'hFEDC_BA98_7654_3210, 8'hAC), 64, -1, -1);
        idle(3);

        // long frame
        pushValid(64'h1122_3344_5566_7788);
        pushError(2'b10);
        applyStimulus(encrypt(64'h1122_3344_5566_7788, 8'hAC), 70, -1, -1);
        checkOutput("long_count_sat", oBit_counter, 64'd64);
        idle(3);

        // ena gating mid-frame
        pushValid(64'hDEAD_BEEF_CAFE_F00D);
        applyStimulus(encrypt(64'hDEAD_BEEF_CAFE_F00D, 8'hAC), 64, 20, -1);
        idle(3);

        // key with extra bits beyond KEY_SIZE
        sendKey(16'h3C80, 10);
        idle(2);
        checkOutput("key10_ready", oKey_ready, 64'h1);
        pushValid(64'h0F1E_2D3C_4B5A_6978);
        applyStimulus(encrypt(64'h0F1E_2D3C_4B5A_6978, 8'h3C), 64, -1, -1);
        idle(3);

        // truncated key reload in the middle of a frame
        pushError(2'b11);
        fork
            applyStimulus(encrypt(64'h0F1E_2D3C_4B5A_6978, 8'h3C), 64, -1, -1);
            begin
                idle(20);
                sendKey(16'hF000, 4);
            end
        join
        checkOutput("reload_key_not_ready", oKey_ready, 64'h0);
        idle(3);

        // reset at bit 30 discards frame and key
        sendKey({8'hAC, 8'h00}, 8);
        idle(2);
        applyStimulus(64'hAD8F_E9CB_2507_6143, 64, -1, 30);
        idle(2);
        pushError(2'b11);
        applyStimulus(64'hAD8F_E9CB_2507_6143, 64, -1, -1);
        idle(3);
        sendKey({8'hAC, 8'h00}, 8);
        idle(2);
        pushValid(64'h0123_4567_89AB_CDEF);
        applyStimulus(64'hAD8F_E9CB_2507_6143, 64, -1, -1);
        idle(5);

        checkOutput("queue_drained", expQ.size(), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
